ssd1331_spi_sequencer: RTL and testbench

Sequencer that owns the MOSI byte buffer (`Nbit_MOSI_SPI_Buffer` feeding `Nbit_MOSI_SPI`) and drives the SSD1331 panel power/reset pins. After reset it powers the panel up and plays a fixed command ROM through the buffer in batches of up to N bytes. It then turns the display on and serves user transfer requests one at a time through a request/acknowledge handshake. It sits between the top-level drawing logic and the SPI buffer and is the only block that pulses the buffer start.

---
 rtl/ssd1331_pkg.sv | 37 +++
 rtl/ssd1331_init_rom.sv | 31 +++
 rtl/ssd1331_spi_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_ssd1331_spi_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd1331_pkg.sv
// Shared constants for the SSD1331 power-up / command sequencer.
// State encodings, init command ROM contents and default delay lengths.
package ssd1331_pkg;

   localparam logic [3:0] ST_PWR_UP       = 4'd0;
   localparam logic [3:0] ST_RES_LOW      = 4'd1;
   localparam logic [3:0] ST_RES_WAIT     = 4'd2;
   localparam logic [3:0] ST_INIT_LOAD    = 4'd3;
   localparam logic [3:0] ST_INIT_WAIT    = 4'd4;
   localparam logic [3:0] ST_VCC_ON       = 4'd5;
   localparam logic [3:0] ST_DISP_ON_LOAD = 4'd6;
   localparam logic [3:0] ST_DISP_ON_WAIT = 4'd7;
   localparam logic [3:0] ST_IDLE         = 4'd8;
   localparam logic [3:0] ST_USER_WAIT    = 4'd9;

   localparam int         ROM_BATCHES = 4;
   localparam logic [1:0] ROM_LAST    = 2'(ROM_BATCHES - 1);
   localparam int         ROM_MAX_LEN = 5;

   // Byte 0 of each batch sits in the low byte and goes out first.
   localparam logic [39:0] ROM_B0 = 40'h00_0000_00AE;
   localparam logic [39:0] ROM_B1 = 40'h00_0000_72A0;
   localparam logic [39:0] ROM_B2 = 40'h00_00A2_00A1;
   localparam logic [39:0] ROM_B3 = 40'h8E_AD3F_A8A4;
   localparam logic [4:0]  ROM_N0 = 5'd1;
   localparam logic [4:0]  ROM_N1 = 5'd2;
   localparam logic [4:0]  ROM_N2 = 5'd4;
   localparam logic [4:0]  ROM_N3 = 5'd5;

   localparam logic [7:0] OP_DISPLAY_ON = 8'hAF;

   localparam int DEF_PWR_WAIT = 20;
   localparam int DEF_RST_LOW  = 6;
   localparam int DEF_RST_WAIT = 6;
   localparam int DEF_VCC_WAIT = 20;

endpackage

// File: rtl/ssd1331_init_rom.sv
// Combinational init command ROM: batch index -> {bytes, D/C flags, length}.
// All init bytes are commands, so D/C is always zero.
module ssd1331_init_rom
   import ssd1331_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N     = 8
)(
   input  logic [1:0]         i_batch,
   output logic [WIDTH*N-1:0] o_data,
   output logic [N-1:0]       o_dc,
   output logic [4:0]         o_n
);

   logic [ROM_MAX_LEN*8-1:0] rom_bytes;

   always_comb begin
      case (i_batch)
         2'd0:    begin rom_bytes = ROM_B0; o_n = ROM_N0; end
         2'd1:    begin rom_bytes = ROM_B1; o_n = ROM_N1; end
         2'd2:    begin rom_bytes = ROM_B2; o_n = ROM_N2; end
         default: begin rom_bytes = ROM_B3; o_n = ROM_N3; end
      endcase
      o_data = '0;
      for (int k = 0; k < ROM_MAX_LEN; k++) begin
         o_data[WIDTH*k +: WIDTH] = WIDTH'(rom_bytes[8*k +: 8]);
      end
      o_dc = '0;
   end

endmodule

// File: rtl/ssd1331_spi_sequencer.sv
// Powers up the SSD1331, plays the init ROM through the MOSI buffer, then
// serves user transfer requests one at a time with a request/ack handshake.
module ssd1331_spi_sequencer
   import ssd1331_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int N        = 8,
   parameter int PWR_WAIT = DEF_PWR_WAIT,
   parameter int RST_LOW  = DEF_RST_LOW,
   parameter int RST_WAIT = DEF_RST_WAIT,
   parameter int VCC_WAIT = DEF_VCC_WAIT
)(
   input  logic               i_SCK,
   input  logic               i_RST,
   input  logic               i_REQ,
   input  logic [WIDTH*N-1:0] i_REQ_DATA,
   input  logic [N-1:0]       i_REQ_DC,
   input  logic [4:0]         i_REQ_N,
   output logic               o_REQ_ACK,
   output logic               o_READY,
   output logic               o_INIT_DONE,
   output logic [WIDTH*N-1:0] o_BUF_DATA,
   output logic [N-1:0]       o_BUF_DC,
   output logic [4:0]         o_BUF_N,
   output logic               o_BUF_START,
   input  logic               i_BYTE_DONE,
   output logic               o_PMODEN,
   output logic               o_RES,
   output logic               o_VCCEN
);

   logic [3:0]         state_q, state_d;
   logic [19:0]        delay_q, delay_d;
   logic [1:0]         batch_q, batch_d;
   logic [4:0]         byte_cnt_q, byte_cnt_d;
   logic [WIDTH*N-1:0] buf_data_q, buf_data_d;
   logic [N-1:0]       buf_dc_q, buf_dc_d;
   logic [4:0]         buf_n_q, buf_n_d;
   logic               start_q, start_d;
   logic               ack_q, ack_d;
   logic               init_done_q, init_done_d;
   logic               pmoden_q, pmoden_d;
   logic               res_q, res_d;
   logic               vccen_q, vccen_d;
   logic               byte_done_q;

   logic               byte_rise;
   logic [4:0]         byte_cnt_inc;
   logic               xfer_done;
   logic [4:0]         req_n_clamped;
   logic [WIDTH*N-1:0] rom_data;
   logic [N-1:0]       rom_dc;
   logic [4:0]         rom_n;

   ssd1331_init_rom #(.WIDTH(WIDTH), .N(N)) u_init_rom (
      .i_batch (batch_q),
      .o_data  (rom_data),
      .o_dc    (rom_dc),
      .o_n     (rom_n)
   );

   assign byte_rise     = i_BYTE_DONE & ~byte_done_q;
   assign byte_cnt_inc  = byte_cnt_q + {4'd0, byte_rise};
   assign xfer_done     = (byte_cnt_inc == buf_n_q);
   assign req_n_clamped = (i_REQ_N > 5'(N)) ? 5'(N) : i_REQ_N;

   always_comb begin
      state_d     = state_q;
      delay_d     = '0;
      batch_d     = batch_q;
      byte_cnt_d  = byte_cnt_q;
      buf_data_d  = buf_data_q;
      buf_dc_d    = buf_dc_q;
      buf_n_d     = buf_n_q;
      start_d     = 1'b0;
      ack_d       = 1'b0;
      init_done_d = init_done_q;

      case (state_q)
         ST_PWR_UP: begin
            if (delay_q == 20'(PWR_WAIT - 1)) state_d = ST_RES_LOW;
            else                              delay_d = delay_q + 20'd1;
         end
         ST_RES_LOW: begin
            if (delay_q == 20'(RST_LOW - 1)) state_d = ST_RES_WAIT;
            else                             delay_d = delay_q + 20'd1;
         end
         ST_RES_WAIT: begin
            if (delay_q == 20'(RST_WAIT - 1)) state_d = ST_INIT_LOAD;
            else                              delay_d = delay_q + 20'd1;
         end
         ST_INIT_LOAD: begin
            buf_data_d = rom_data;
            buf_dc_d   = rom_dc;
            buf_n_d    = rom_n;
            byte_cnt_d = '0;
            start_d    = 1'b1;
            state_d    = ST_INIT_WAIT;
         end
         ST_INIT_WAIT: begin
            byte_cnt_d = byte_cnt_inc;
            if (xfer_done) begin
               batch_d = batch_q + 2'd1;
               state_d = (batch_q == ROM_LAST) ? ST_VCC_ON : ST_INIT_LOAD;
            end
         end
         ST_VCC_ON: begin
            if (delay_q == 20'(VCC_WAIT - 1)) state_d = ST_DISP_ON_LOAD;
            else                              delay_d = delay_q + 20'd1;
         end
         ST_DISP_ON_LOAD: begin
            buf_data_d              = '0;
            buf_data_d[WIDTH-1:0]   = WIDTH'(OP_DISPLAY_ON);
            buf_dc_d                = '0;
            buf_n_d                 = 5'd1;
            byte_cnt_d              = '0;
            start_d                 = 1'b1;
            state_d                 = ST_DISP_ON_WAIT;
         end
         ST_DISP_ON_WAIT: begin
            byte_cnt_d = byte_cnt_inc;
            if (xfer_done) begin
               init_done_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_IDLE: begin
            // ack_q blocks a second capture of a request already acknowledged.
            if (i_REQ && !ack_q) begin
               buf_data_d = i_REQ_DATA;
               buf_dc_d   = i_REQ_DC;
               buf_n_d    = req_n_clamped;
               byte_cnt_d = '0;
               ack_d      = 1'b1;
               if (req_n_clamped != 5'd0) begin
                  start_d = 1'b1;
                  state_d = ST_USER_WAIT;
               end
            end
         end
         ST_USER_WAIT: begin
            byte_cnt_d = byte_cnt_inc;
            if (xfer_done) state_d = ST_IDLE;
         end
         default: state_d = ST_PWR_UP;
      endcase

      pmoden_d = 1'b1;
      res_d    = (state_d != ST_RES_LOW);
      vccen_d  = vccen_q | (state_d == ST_VCC_ON);
   end

   always_ff @(posedge i_SCK or posedge i_RST) begin
      if (i_RST) begin
         state_q     <= ST_PWR_UP;
         delay_q     <= '0;
         batch_q     <= '0;
         byte_cnt_q  <= '0;
         buf_data_q  <= '0;
         buf_dc_q    <= '0;
         buf_n_q     <= '0;
         start_q     <= 1'b0;
         ack_q       <= 1'b0;
         init_done_q <= 1'b0;
         pmoden_q    <= 1'b0;
         res_q       <= 1'b0;
         vccen_q     <= 1'b0;
         byte_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         delay_q     <= delay_d;
         batch_q     <= batch_d;
         byte_cnt_q  <= byte_cnt_d;
         buf_data_q  <= buf_data_d;
         buf_dc_q    <= buf_dc_d;
         buf_n_q     <= buf_n_d;
         start_q     <= start_d;
         ack_q       <= ack_d;
         init_done_q <= init_done_d;
         pmoden_q    <= pmoden_d;
         res_q       <= res_d;
         vccen_q     <= vccen_d;
         byte_done_q <= i_BYTE_DONE;
      end
   end

   assign o_REQ_ACK   = ack_q;
   assign o_READY     = (state_q == ST_IDLE) & ~ack_q;
   assign o_INIT_DONE = init_done_q;
   assign o_BUF_DATA  = buf_data_q;
   assign o_BUF_DC    = buf_dc_q;
   assign o_BUF_N     = buf_n_q;
   assign o_BUF_START = start_q;
   assign o_PMODEN    = pmoden_q;
   assign o_RES       = res_q;
   assign o_VCCEN     = vccen_q;

endmodule

// File: tb/tb_ssd1331_spi_sequencer.sv
// Bench for ssd1331_spi_sequencer: SPI-core model, load scoreboard,
// table of user requests and hand-written reset / back-to-back sequences.
module tb_ssd1331_spi_sequencer;

   localparam int WIDTH    = 8;
   localparam int N        = 8;
   localparam int PWR_WAIT = 20;
   localparam int RST_LOW  = 6;
   localparam int RST_WAIT = 6;
   localparam int VCC_WAIT = 20;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  dc;
      logic [4:0]  n;
   } load_t;

   typedef struct {
      logic [4:0]  req_n;
      logic [63:0] data;
      logic [7:0]  dc;
      logic [4:0]  exp_n;
      int          hold;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        req;
   logic [63:0] req_data;
   logic [7:0]  req_dc;
   logic [4:0]  req_n;
   logic        byte_done;
   logic        model_done;
   logic        man_done;
   logic        ack, ready, init_done, buf_start, pmoden, res_n, vccen;
   logic [63:0] buf_data;
   logic [7:0]  buf_dc;
   logic [4:0]  buf_n;

   int    tests = 0;
   int    fails = 0;
   load_t exp_q[$];
   bit    spi_auto = 1'b1;
   int    hold_cycles = 1;
   int    bytes_sent = 0;
   int    start_cnt = 0;
   int    ack_cnt = 0;
   logic  prev_start = 1'b0;
   vec_t  vecs [5];

   assign byte_done = model_done | man_done;

   ssd1331_spi_sequencer #(
      .WIDTH(WIDTH), .N(N), .PWR_WAIT(PWR_WAIT), .RST_LOW(RST_LOW),
      .RST_WAIT(RST_WAIT), .VCC_WAIT(VCC_WAIT)
   ) dut (
      .i_SCK       (clk),
      .i_RST       (rst),
      .i_REQ       (req),
      .i_REQ_DATA  (req_data),
      .i_REQ_DC    (req_dc),
      .i_REQ_N     (req_n),
      .o_REQ_ACK   (ack),
      .o_READY     (ready),
      .o_INIT_DONE (init_done),
      .o_BUF_DATA  (buf_data),
      .o_BUF_DC    (buf_dc),
      .o_BUF_N     (buf_n),
      .o_BUF_START (buf_start),
      .i_BYTE_DONE (byte_done),
      .o_PMODEN    (pmoden),
      .o_RES       (res_n),
      .o_VCCEN     (vccen)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] byte_mask(input logic [4:0] n);
      logic [63:0] m;
      m = '0;
      for (int k = 0; k < 8; k++) if (k < int'(n)) m[8*k +: 8] = 8'hFF;
      return m;
   endfunction

   function automatic logic [7:0] dc_mask(input logic [4:0] n);
      logic [7:0] m;
      m = '0;
      for (int k = 0; k < 8; k++) if (k < int'(n)) m[k] = 1'b1;
      return m;
   endfunction

   function automatic load_t mk_load(input logic [63:0] d, input logic [7:0] dc, input logic [4:0] n);
      load_t l;
      l.data = d;
      l.dc   = dc;
      l.n    = n;
      return l;
   endfunction

   // Scoreboard: every START pops one expected load.
   initial begin : start_monitor
      load_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_start = 1'b0;
         end else begin
            if (ack) ack_cnt++;
            if (buf_start) begin
               start_cnt++;
               chk("start_one_cycle", prev_start, 1'b0);
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_start: got START with n=%0d, expected none", buf_n);
               end else begin
                  e = exp_q.pop_front();
                  chk("load_n", buf_n, e.n);
                  chk("load_data", buf_data & byte_mask(e.n), e.data & byte_mask(e.n));
                  chk("load_dc", buf_dc & dc_mask(e.n), e.dc & dc_mask(e.n));
               end
            end
            prev_start = buf_start;
         end
      end
   end

   // SPI core model: one byte-done pulse per byte after each START.
   initial begin : spi_model
      logic [63:0] cd;
      logic [7:0]  cdc;
      logic [4:0]  cn;
      model_done = 1'b0;
      forever begin
         @(negedge clk);
         if (spi_auto && !rst && buf_start) begin
            cd  = buf_data;
            cdc = buf_dc;
            cn  = buf_n;
            for (int k = 0; k < int'(cn); k++) begin
               repeat (2) @(negedge clk);
               chk("buf_stable", {buf_data, buf_dc, buf_n}, {cd, cdc, cn});
               model_done = 1'b1;
               bytes_sent++;
               repeat (hold_cycles) @(negedge clk);
               model_done = 1'b0;
            end
         end
      end
   end

   task automatic do_init(input string tag);
      int  cyc;
      int  res_low;
      int  vcc_at;
      bit  af_seen;
      exp_q.push_back(mk_load(64'hAE, 8'h00, 5'd1));
      exp_q.push_back(mk_load(64'h72A0, 8'h00, 5'd2));
      exp_q.push_back(mk_load(64'h00A200A1, 8'h00, 5'd4));
      exp_q.push_back(mk_load(64'h8EAD3FA8A4, 8'h00, 5'd5));
      exp_q.push_back(mk_load(64'hAF, 8'h00, 5'd1));
      cyc = 0; res_low = 0; vcc_at = -1; af_seen = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      while (!ready && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) chk({tag, "_pwr_first_cycle"}, {pmoden, res_n, vccen}, 3'b110);
         if (!res_n) res_low++;
         if (vccen && vcc_at < 0) vcc_at = cyc;
         if (buf_start && buf_n == 5'd1 && buf_data[7:0] == 8'hAF) begin
            af_seen = 1'b1;
            chk({tag, "_vcc_before_af"}, cyc - vcc_at, VCC_WAIT + 1);
            chk({tag, "_no_done_before_af"}, init_done, 1'b0);
         end
      end
      chk({tag, "_ready_reached"}, ready, 1'b1);
      chk({tag, "_res_low_cycles"}, res_low, RST_LOW);
      chk({tag, "_af_seen"}, af_seen, 1'b1);
      chk({tag, "_init_done"}, init_done, 1'b1);
      chk({tag, "_rom_loads_consumed"}, exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin : main
      int cyc, s0, a0, b0, nacks, ready_at, ack2_at;
      rst = 1'b0; req = 1'b0; req_data = '0; req_dc = '0; req_n = '0; man_done = 1'b0;

      vecs[0] = '{5'd4,  64'h00000000_C0300C03, 8'h0C, 5'd4, 1};
      vecs[1] = '{5'd8,  64'h01234567_89ABCDEF, 8'hAA, 5'd8, 1};
      vecs[2] = '{5'd12, 64'hFEDCBA98_76543210, 8'h5A, 5'd8, 3};
      vecs[3] = '{5'd0,  64'h00000000_00001111, 8'hFF, 5'd0, 1};
      vecs[4] = '{5'd1,  64'h00000000_0000005C, 8'h01, 5'd1, 2};

      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {ack, ready, init_done, buf_data, buf_dc, buf_n, buf_start,
                            pmoden, res_n, vccen}, '0);
      do_init("init1");

      foreach (vecs[i]) begin
         hold_cycles = vecs[i].hold;
         b0 = bytes_sent; a0 = ack_cnt; s0 = start_cnt;
         if (vecs[i].exp_n != 5'd0)
            exp_q.push_back(mk_load(vecs[i].data, vecs[i].dc, vecs[i].exp_n));
         req = 1'b1; req_data = vecs[i].data; req_dc = vecs[i].dc; req_n = vecs[i].req_n;
         @(negedge clk);
         chk($sformatf("v%0d_ack_latency", i), ack, 1'b1);
         chk($sformatf("v%0d_ready_low_in_ack", i), ready, 1'b0);
         chk($sformatf("v%0d_start_with_ack", i), buf_start, vecs[i].exp_n != 5'd0);
         chk($sformatf("v%0d_buf_n", i), buf_n, vecs[i].exp_n);
         req = 1'b0;
         cyc = 0;
         while (!ready && cyc < 500) begin
            @(negedge clk);
            cyc++;
         end
         chk($sformatf("v%0d_ready_back", i), ready, 1'b1);
         if (vecs[i].exp_n == 5'd0) chk($sformatf("v%0d_ready_next_cycle", i), cyc, 1);
         chk($sformatf("v%0d_bytes_at_ready", i), bytes_sent - b0, int'(vecs[i].exp_n));
         repeat (vecs[i].hold + 3) @(negedge clk);
         chk($sformatf("v%0d_single_ack", i), ack_cnt - a0, 1);
         chk($sformatf("v%0d_starts", i), start_cnt - s0, int'(vecs[i].exp_n != 5'd0));
      end

      // Back-to-back: request held across two full transfers.
      hold_cycles = 1;
      b0 = bytes_sent; a0 = ack_cnt; s0 = start_cnt;
      exp_q.push_back(mk_load(64'h8899AABB_CCDDEEFF, 8'hAA, 5'd8));
      exp_q.push_back(mk_load(64'h8899AABB_CCDDEEFF, 8'hAA, 5'd8));
      req = 1'b1; req_data = 64'h8899AABB_CCDDEEFF; req_dc = 8'hAA; req_n = 5'd8;
      nacks = 0; cyc = 0; ready_at = -1; ack2_at = -100;
      while (nacks < 2 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (ready && nacks == 1 && ready_at < 0) ready_at = cyc;
         if (ack) begin
            nacks++;
            if (nacks == 2) begin
               ack2_at = cyc;
               req = 1'b0;
            end
         end
      end
      chk("b2b_ack_after_idle", ack2_at - ready_at, 1);
      cyc = 0;
      while (!ready && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      chk("b2b_bytes", bytes_sent - b0, 16);
      repeat (4) @(negedge clk);
      chk("b2b_acks", ack_cnt - a0, 2);
      chk("b2b_starts", start_cnt - s0, 2);
      chk("b2b_queue_empty", exp_q.size(), 0);

      // Reset during the third byte of a user transfer.
      spi_auto = 1'b0;
      exp_q.push_back(mk_load(64'h00000000_C0300C03, 8'h0C, 5'd4));
      req = 1'b1; req_data = 64'h00000000_C0300C03; req_dc = 8'h0C; req_n = 5'd4;
      @(negedge clk);
      chk("rst_test_ack", ack, 1'b1);
      req = 1'b0;
      for (int k = 0; k < 2; k++) begin
         repeat (2) @(negedge clk);
         man_done = 1'b1;
         @(negedge clk);
         man_done = 1'b0;
      end
      chk("rst_test_busy_after_2_bytes", ready, 1'b0);
      repeat (2) @(negedge clk);
      man_done = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("async_reset_outputs", {ack, ready, init_done, buf_data, buf_dc, buf_n, buf_start,
                                  pmoden, res_n, vccen}, '0);
      chk("rst_test_queue_empty", exp_q.size(), 0);
      man_done = 1'b0;
      spi_auto = 1'b1;
      repeat (3) @(negedge clk);
      do_init("init2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
